// File: rtl/tt_um_taghreed_serial_adder_ctrl.sv
// tt_um_taghreed_serial_adder_ctrl
// Bit-serial add controller. Two operands are captured from ui_in. They are
// then pushed LSB-first through one full-adder cell, one bit per enabled
// clock, with a registered carry. The parallel result appears on uo_out.
// A start/done handshake on uio sequences each operation.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, uio_in[3] acts as a subtract select, sampled at start.
//   When undefined, uio_in[3] is a plain carry-in.
module tt_um_taghreed_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // The counter needs at least one bit, even for a single-bit adder.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_SUB_EN
  logic             r_sub;
`endif

  logic             w_load_a;
  logic             w_load_b;
  logic             w_start;
  logic             w_cin;
  logic [WIDTH-1:0] w_operand;
  logic             w_b_bit;
  logic             w_sum;
  logic             w_carry_next;
  logic [7:0]       w_res_ext;
  logic             w_unused;

  // Full-adder sum: the only arithmetic resource in the block.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Full-adder carry: the majority of the three inputs.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

  // Shift a register right by one and insert a new bit at the MSB.
  // This form also works for WIDTH == 1, where the slice form would not.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic             b);
    logic [WIDTH-1:0] t;
    t = v >> 1;
    t[WIDTH-1] = b;
    return t;
  endfunction

  assign w_load_a  = uio_in[0];
  assign w_load_b  = uio_in[1];
  assign w_start   = uio_in[2];
  assign w_cin     = uio_in[3];
  assign w_operand = ui_in[WIDTH-1:0];

  // Upper input bits are don't-care.
  // Folding the buses here keeps the unused bits visibly accounted for.
  assign w_unused = ^{ui_in, uio_in[7:4]};

`ifdef SERIAL_ADDER_SUB_EN
  // For subtraction, each opb bit is inverted as it enters the adder.
  // Together with a carry-in of 1 this forms the two's complement.
  assign w_b_bit = r_opb[0] ^ r_sub;
`else
  assign w_b_bit = r_opb[0];
`endif

  assign w_sum        = fa_sum(r_opa[0], w_b_bit, r_carry);
  assign w_carry_next = fa_carry(r_opa[0], w_b_bit, r_carry);

  // Zero-extend the result onto the 8-bit output bus.
  always_comb begin
    w_res_ext = '0;
    w_res_ext[WIDTH-1:0] = r_res;
  end

  assign uo_out  = w_res_ext;
  assign uio_out = {1'b0, r_carry, r_done, r_busy, 4'b0000};
  assign uio_oe  = 8'hF0;

  // Controller FSM and serial datapath.
  // Nothing changes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // Start wins over loads in the same cycle.
            // The previously loaded operands are used.
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_res   <= '0;
            r_count <= '0;
            // A subtract also starts with carry = 1.
            // So in both builds the carry seeds from uio_in[3].
            r_carry <= w_cin;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= w_cin;
`endif
          end else begin
            if (w_load_a) r_opa <= w_operand;
            if (w_load_b) r_opb <= w_operand;
          end
        end

        S_RUN: begin
          r_carry <= w_carry_next;
          r_res   <= shift_in(r_res, w_sum);
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          if (r_count == LAST_BIT) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end

        S_DONE: begin
          // Hold here until start is released.
          // The result and carry stay valid afterwards.
          if (!w_start) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_taghreed_serial_adder_ctrl.sv
// Self-checking bench for tt_um_taghreed_serial_adder_ctrl.
// Expected results come from a plain-arithmetic model of the add/subtract.
module tb_tt_um_taghreed_serial_adder_ctrl;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  tt_um_taghreed_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model. Returns {cout, result}.
  function automatic logic [8:0] model(input int a, input int b, input bit c);
    int aw, bw, r;
    bit co;
    logic [8:0] ret;
    aw = a & MASK;
    bw = b & MASK;
`ifdef SERIAL_ADDER_SUB_EN
    if (c) begin
      r  = (aw - bw) & MASK;
      co = (aw >= bw);
    end else begin
      r  = aw + bw;
      co = (r > MASK);
      r  = r & MASK;
    end
`else
    r  = aw + bw + int'(c);
    co = (r > MASK);
    r  = r & MASK;
`endif
    ret[7:0] = 8'(r);
    ret[8]   = co;
    return ret;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    uio_in = 8'h01; ui_in = a; tick();
    uio_in = 8'h02; ui_in = b; tick();
    uio_in = 8'h00; ui_in = 8'h00;
  endtask

  // Pulse start with the given uio word.
  // Waits (bounded) for done, samples the outputs, then acknowledges.
  task automatic run_op(input logic [7:0] start_word, output int lat,
                        output logic [7:0] res, output logic co);
    uio_in = start_word;
    tick();
    uio_in = 8'h00;
    ui_in  = 8'h00;
    lat = 0;
    while (!uio_out[5] && lat < 100) begin
      tick();
      lat++;
    end
    res = uo_out;
    co  = uio_out[6];
    tick();
  endtask

  task automatic test_reset();
    ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL reset_uo_out: got %h want 00", uo_out); end
    n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
    n_cmp++; if (uio_oe !== 8'hF0) begin n_bad++; $display("FAIL reset_uio_oe: got %h want F0", uio_oe); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_basic();
    int lat; logic [7:0] res; logic co; logic [8:0] exp;
    load_ops(8'h3C, 8'h5A);
    exp = model(32'h3C, 32'h5A, 1'b0);
    run_op(8'h04, lat, res, co);
    n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL add_latency: got %0d want %0d", lat, W); end
    n_cmp++; if (res !== exp[7:0]) begin n_bad++; $display("FAIL add_result: got %h want %h", res, exp[7:0]); end
    n_cmp++; if (co !== exp[8]) begin n_bad++; $display("FAIL add_cout: got %b want %b", co, exp[8]); end
    n_cmp++; if (uio_out[5:4] !== 2'b00) begin n_bad++; $display("FAIL ack_flags: got %b want 00", uio_out[5:4]); end
    n_cmp++; if (uo_out !== exp[7:0]) begin n_bad++; $display("FAIL hold_after_ack: got %h want %h", uo_out, exp[7:0]); end
    n_cmp++; if (uio_out[6] !== exp[8]) begin n_bad++; $display("FAIL cout_hold: got %b want %b", uio_out[6], exp[8]); end
  endtask

  task automatic test_carry();
    int lat; logic [7:0] res; logic co; logic [8:0] exp;
    load_ops(8'hFF, 8'h01);
    exp = model(32'hFF, 32'h01, 1'b0);
    run_op(8'h04, lat, res, co);
    n_cmp++; if (res !== exp[7:0]) begin n_bad++; $display("FAIL carry_result: got %h want %h", res, exp[7:0]); end
    n_cmp++; if (co !== exp[8]) begin n_bad++; $display("FAIL carry_cout: got %b want %b", co, exp[8]); end
    load_ops(8'h00, 8'h00);
    exp = model(0, 0, 1'b1);
    run_op(8'h0C, lat, res, co);
    n_cmp++; if (res !== exp[7:0]) begin n_bad++; $display("FAIL cin_result: got %h want %h", res, exp[7:0]); end
    n_cmp++; if (co !== exp[8]) begin n_bad++; $display("FAIL cin_cout: got %b want %b", co, exp[8]); end
  endtask

  task automatic test_handshake();
    int nbusy, ndone, nboth; logic [8:0] exp; logic [7:0] held;
    load_ops(8'h3C, 8'h5A);
    exp = model(32'h3C, 32'h5A, 1'b0);
    nbusy = 0; ndone = 0; nboth = 0;
    uio_in = 8'h04;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uio_out[4]) nbusy++;
      if (uio_out[5]) ndone++;
      if (uio_out[4] && uio_out[5]) nboth++;
    end
    n_cmp++; if (nbusy !== W) begin n_bad++; $display("FAIL hs_busy_cycles: got %0d want %0d", nbusy, W); end
    n_cmp++; if (ndone !== 20 - W) begin n_bad++; $display("FAIL hs_done_cycles: got %0d want %0d", ndone, 20 - W); end
    n_cmp++; if (nboth !== 0) begin n_bad++; $display("FAIL hs_overlap: got %0d want 0", nboth); end
    held = uo_out;
    n_cmp++; if (held !== exp[7:0]) begin n_bad++; $display("FAIL hs_result: got %h want %h", held, exp[7:0]); end
    uio_in = 8'h00;
    tick();
    n_cmp++; if (uio_out[5] !== 1'b0) begin n_bad++; $display("FAIL hs_ack: got done=%b want 0", uio_out[5]); end
    n_cmp++; if (uo_out !== exp[7:0]) begin n_bad++; $display("FAIL hs_hold: got %h want %h", uo_out, exp[7:0]); end
  endtask

  task automatic test_start_priority();
    int lat; logic [7:0] res; logic co; logic [8:0] exp;
    load_ops(8'h01, 8'h02);
    exp = model(1, 2, 1'b0);
    ui_in = 8'h77;
    run_op(8'h07, lat, res, co);
    n_cmp++; if (res !== exp[7:0]) begin n_bad++; $display("FAIL start_priority: got %h want %h", res, exp[7:0]); end
  endtask

  task automatic test_stall();
    int lat; logic [7:0] a, b, snap; logic [8:0] exp; int stall_bad;
    a = 8'($urandom); b = 8'($urandom);
    load_ops(a, b);
    exp = model(int'(a), int'(b), 1'b0);
    uio_in = 8'h04; tick(); uio_in = 8'h00;
    tick(); tick(); tick();
    snap = uo_out;
    ena = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (uo_out !== snap || uio_out[4] !== 1'b1) stall_bad++;
    end
    ena = 1'b1;
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_frozen: got %0d changes want 0", stall_bad); end
    lat = 3 + 5;
    while (!uio_out[5] && lat < 100) begin tick(); lat++; end
    n_cmp++; if (lat !== W + 5) begin n_bad++; $display("FAIL stall_latency: got %0d want %0d", lat, W + 5); end
    n_cmp++; if (uo_out !== exp[7:0]) begin n_bad++; $display("FAIL stall_result: got %h want %h", uo_out, exp[7:0]); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int lat; logic [7:0] res; logic co; logic [8:0] exp;
    load_ops(8'h0F, 8'h00);
    uio_in = 8'h04; tick(); uio_in = 8'h00;
    tick(); tick(); tick(); tick();
    n_cmp++; if (uo_out === 8'h00) begin n_bad++; $display("FAIL midrun_partial: got %h want nonzero", uo_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL midrun_reset_uo: got %h want 00", uo_out); end
    n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL midrun_reset_uio: got %h want 00", uio_out); end
    rst_n = 1'b1;
    tick();
    load_ops(8'h21, 8'h43);
    exp = model(32'h21, 32'h43, 1'b0);
    run_op(8'h04, lat, res, co);
    n_cmp++; if (res !== exp[7:0]) begin n_bad++; $display("FAIL post_reset_op: got %h want %h", res, exp[7:0]); end
  endtask

  task automatic test_random();
    int lat; logic [7:0] a, b; logic c; logic [8:0] exp;
    for (int k = 0; k < 24; k++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      load_ops(a, b);
      exp = model(int'(a), int'(b), c);
      uio_in = {4'h0, c, 3'b100};
      tick();
      lat = 0;
      // Junk on load and cin during RUN must be ignored; start stays low.
      while (!uio_out[5] && lat < 100) begin
        uio_in = 8'($urandom) & 8'hFB;
        ui_in  = 8'($urandom);
        tick();
        lat++;
      end
      uio_in = 8'h00;
      n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, W); end
      n_cmp++; if ({uio_out[6], uo_out} !== exp) begin
        n_bad++; $display("FAIL rand_result[%0d]: a=%h b=%h c=%b got %b_%h want %b_%h",
                          k, a, b, c, uio_out[6], uo_out, exp[8], exp[7:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry();
    test_handshake();
    test_start_priority();
    test_stall();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_taghreed_serial_adder_ctrl.md
# tt_um_taghreed_serial_adder_ctrl

Bit-serial add controller built around a single 1-bit full-adder cell (sum = a^b^c, carry = ab | c(a^b)). It captures two operands from the dedicated input bus, sequences them LSB-first through the full adder one bit per clock with a registered carry, and presents the parallel result with a start/done handshake. It is a standard Tiny Tapeout user top and reuses the existing full-adder equations as its only arithmetic resource.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  clock enable; low freezes all state
- ui_in  input  8  operand data; ui_in[WIDTH-1:0] used, upper bits ignored
- uio_in  input  8  [0] load_a, [1] load_b, [2] start, [3] cin (sub with macro); [7:4] ignored
- uo_out  output  8  result register; bits above WIDTH-1 read 0
- uio_out  output  8  [4] busy, [5] done, [6] cout, [7] and [3:0] tied 0
- uio_oe  output  8  constant 8'hF0

## Operation
- Registers: opa, opb, res (WIDTH each), carry, count (0..WIDTH-1), state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - load_a=1 -> opa <= ui_in[WIDTH-1:0].
  - load_b=1 -> opb <= ui_in[WIDTH-1:0].
  - load_a and load_b together -> both load the same value.
  - start=1 -> RUN, res <= 0, count <= 0, carry <= cin.
  - start has priority: loads in the same cycle are ignored and the previous operands are used.
- RUN, each enabled edge:
  - s = opa[0]^opb[0]^carry; carry <= maj(opa[0], opb[0], carry).
  - res <= {s, res[WIDTH-1:1]}; opa and opb shift right by 1; count += 1.
  - When count == WIDTH-1 -> DONE.
  - load_a, load_b, start and cin are ignored.
- DONE:
  - done=1; res holds opa+opb+cin mod 2^WIDTH; cout = final carry.
  - Stays in DONE while start=1; returns to IDLE on the first enabled edge with start=0 (acknowledge).
  - res and cout are held after the return to IDLE until the next start.
- Flags: busy = (state==RUN); done = (state==DONE); cout = carry register.
- Operands are consumed by shifting, so both must be reloaded before every operation.

## Timing
- Reset (asynchronous, rst_n=0):
  - state IDLE; opa, opb, res, carry, count = 0.
  - uo_out = 0x00; uio_out = 0x00; uio_oe = 0xF0 at all times.
- Latency:
  - start sampled high at edge E0 -> busy high after E0.
  - done high after edge E0+WIDTH, i.e. exactly WIDTH RUN cycles.
  - busy and done are never high together.
- Minimum op-to-op cycle: WIDTH+2 edges (start, WIDTH RUN edges, one acknowledge edge). Start must be low at the acknowledge edge.
- ena=0: no register changes in any state, including RUN; the count does not advance.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all registers cleared; the partial result is lost.
- WIDTH=1: RUN lasts one cycle; the count never increments past 0.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - uio_in[3] is sub, sampled at start.
  - sub=1: opb bits are inverted entering the full adder and carry starts at 1, giving res = opa-opb mod 2^WIDTH and cout = 1 when no borrow occurs.
  - sub=0: plain add with carry-in 0.
- Macro undefined: uio_in[3] is a raw carry-in, and no inversion logic is present.

## Test plan
- Add, no carry: reset; load A=0x3C, B=0x5A; start with cin=0 -> done after 8 cycles, uo_out=0x96, cout=0.
- Carry out: A=0xFF, B=0x01, cin=0 -> uo_out=0x00, cout=1. Separate op: A=B=0x00, cin=1 -> uo_out=0x01, cout=0.
- Handshake: keep start high 20 cycles -> busy high for 8 cycles, then done stays high; drop start -> IDLE next edge, uo_out holds 0x96. Start plus load_a in the same IDLE cycle -> loads ignored, old operands used.
- Stall and reset: ena=0 for 5 cycles mid-RUN -> done delayed by exactly 5 cycles, same result. Reset at RUN cycle 4 -> uo_out=0x00, busy=0, done=0 immediately.
- SERIAL_ADDER_SUB_EN: A=0x10, B=0x01, sub=1 -> uo_out=0x0F, cout=1. A=0x01, B=0x02 -> uo_out=0xFF, cout=0.
- WIDTH=4 build: A=0xFB, B=0x07 -> only low nibbles used, uo_out=0x02, cout=1, done after 4 cycles.
